// File: rtl/regfile_sb_pkg.sv
// Shared types and helpers for the register file / scoreboard.
// stage_id imports this package for its hazard logic.
package regfile_pkg;

   // Address width for a register file of n entries (at least one bit).
   function automatic int addr_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   localparam int NREGS_DEF = 32;
   localparam int AW_DEF    = addr_w(NREGS_DEF);
   localparam int CNT_W_DEF = 2;

   typedef logic [AW_DEF-1:0]    reg_addr_t;
   typedef logic [CNT_W_DEF-1:0] sb_cnt_t;

   localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_sb_sb_counter.sv
// Pending-write counter for one architectural register.
// Counts up on an accepted issue, down by the number of retiring writers.
// Decrements floor at zero, and the total never passes the maximum.
// A flush clears the count, but an issue accepted in the same cycle
// still leaves one producer outstanding.
module sb_counter #(
   parameter int CNT_W = 2,
   parameter int DEC_W = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic [DEC_W-1:0] dec,
   input  logic             flush,
   output logic [CNT_W-1:0] count,
   output logic             full
);

   // One bit wider than either operand so the arithmetic cannot wrap.
   localparam int SW = ((CNT_W > DEC_W) ? CNT_W : DEC_W) + 1;
   localparam logic [SW-1:0] MAX = SW'((1 << CNT_W) - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SW-1:0]    cur, sub, sum;

   // Next count: floored decrement, then increment, with flush override.
   always_comb begin
      cur = SW'(cnt_q);
      sub = (cur > SW'(dec)) ? (cur - SW'(dec)) : '0;
      sum = sub + SW'(inc);
      if (flush) sum = SW'(inc);
      if (sum > MAX) sum = MAX;
      cnt_d = CNT_W'(sum);
   end

   // Counter state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign count = cnt_q;
   assign full  = &cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port integer register file with a pending-write scoreboard.
// Reads are combinational and bypass same-cycle writes. Each register
// except r0 has a counter of in-flight producers, which stage_id uses
// to stall only on true dependences.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int NREAD  = 2,
   parameter int NWRITE = 1,
   parameter int CNT_W  = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NREAD*addr_w(NREGS)-1:0]  rd_addr,
   output logic [NREAD*XLEN-1:0]           rd_data,
   output logic [NREAD-1:0]                rd_busy,
   input  logic [NWRITE-1:0]               wr_en,
   input  logic [NWRITE*addr_w(NREGS)-1:0] wr_addr,
   input  logic [NWRITE*XLEN-1:0]          wr_data,
   input  logic [NWRITE-1:0]               wr_clr,
   input  logic                            iss_valid,
   input  logic [addr_w(NREGS)-1:0]        iss_addr,
   output logic                            iss_ready,
   input  logic                            flush
);

   localparam int AW    = addr_w(NREGS);
   localparam int DEC_W = addr_w(NWRITE + 1);
   localparam int SW    = ((CNT_W > DEC_W) ? CNT_W : DEC_W) + 1;

   logic [XLEN-1:0]  regs_q [NREGS];
   logic [XLEN-1:0]  regs_d [NREGS];
   logic [DEC_W-1:0] dec    [NREGS];
   logic [CNT_W-1:0] cnt    [NREGS];
   logic             full   [NREGS];
   logic [NREGS-1:0] inc;
   logic             iss_acc;

   // Register writes: ascending port order, so the highest port wins; r0 never stored.
   always_comb begin
      regs_d = regs_q;
      for (int j = 0; j < NWRITE; j++) begin
         if (wr_en[j] && (wr_addr[j*AW +: AW] != AW'(ZERO_REG)))
            regs_d[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
      end
   end

   // Register data state; reset clears everything and drops the in-flight write.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   // Count the retiring writers that target each register this cycle.
   always_comb begin
      for (int r = 0; r < NREGS; r++) begin
         dec[r] = '0;
         for (int j = 0; j < NWRITE; j++) begin
            if (wr_clr[j] && (wr_addr[j*AW +: AW] == AW'(r)))
               dec[r] = dec[r] + DEC_W'(1);
         end
      end
   end

   // Issue acceptance uses only registered counter state, so it has no path from wr_clr.
   assign iss_ready = (iss_addr == AW'(ZERO_REG)) || !full[iss_addr];
   assign iss_acc   = iss_valid && iss_ready;

   for (genvar r = 0; r < NREGS; r++) begin : g_sb
      if (r == 0) begin : g_zero
         assign inc[r]  = 1'b0;
         assign cnt[r]  = '0;
         assign full[r] = 1'b0;
      end else begin : g_cnt
         assign inc[r] = iss_acc && (iss_addr == AW'(r));
         sb_counter #(
            .CNT_W (CNT_W),
            .DEC_W (DEC_W)
         ) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (inc[r]),
            .dec   (dec[r]),
            .flush (flush),
            .count (cnt[r]),
            .full  (full[r])
         );
      end
   end

   // Read ports: stored value, overridden by a same-cycle write, with the highest port last.
   // Busy means writes are still outstanding after this cycle's retires.
   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int i = 0; i < NREAD; i++) begin
         automatic logic [AW-1:0]   a = rd_addr[i*AW +: AW];
         automatic logic [XLEN-1:0] d = regs_q[a];
         for (int j = 0; j < NWRITE; j++) begin
            if (wr_en[j] && (wr_addr[j*AW +: AW] == a))
               d = wr_data[j*XLEN +: XLEN];
         end
         if ((a == AW'(ZERO_REG)) || !rst) d = '0;
         rd_data[i*XLEN +: XLEN] = d;
         rd_busy[i] = rst && (SW'(cnt[a]) > SW'(dec[a]));
      end
   end

endmodule
